// File: rtl/ip_seq_ctrl.sv
// ip_seq_ctrl: job sequencer for the 32-word AXI4-Stream buffer IP.
// Accepts LOAD / UNLOAD / SHUTDOWN jobs, walks the IP through enable, first
// load, DMA_VALID re-arm and command pulses, and counts stream beats to detect
// block completion.
// Optional feature: define IP_SEQ_WDOG_EN to build the beat watchdog.
// Ports:
//   clk, rst (async, active-high)
//   cmd_valid, cmd_op[1:0], cmd_ready     : job request handshake
//   done, err, err_code[1:0], busy        : job status
//   blk_cnt[15:0]                         : completed job count (wraps)
//   ip_en, ip_dma_valid, ip_command[1:0]  : IP control pins
//   s_beat, m_beat, m_last                : IP stream handshakes
module ip_seq_ctrl #(
    parameter int unsigned BLOCK_LEN  = 32,
    parameter int unsigned HS_CYC     = 2,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned WDOG_CYC   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] blk_cnt,
    output logic        ip_en,
    output logic        ip_dma_valid,
    output logic [1:0]  ip_command,
    input  logic        s_beat,
    input  logic        m_beat,
    input  logic        m_last
);
    localparam int unsigned CNT_W     = $clog2(BLOCK_LEN) + 1;
    localparam int unsigned TMR_MAX_A = (WDOG_CYC > HS_CYC) ? WDOG_CYC : HS_CYC;
    localparam int unsigned TMR_MAX_B = (TMR_MAX_A > SETTLE_CYC) ? TMR_MAX_A : SETTLE_CYC;
    localparam int unsigned TMR_MAX   = (TMR_MAX_B > 2) ? TMR_MAX_B : 2;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX) + 1;

    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_UNLOAD  = 2'd2;
    localparam logic [1:0] OP_SHUT    = 2'd3;
    localparam logic [1:0] EC_ILLEGAL = 2'd1;
    localparam logic [1:0] EC_TLAST   = 2'd2;
`ifdef IP_SEQ_WDOG_EN
    localparam logic [1:0] EC_WDOG    = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_OFF, S_BOOT, S_READY, S_ISSUE, S_RUN, S_HS_LO, S_HS_HI, S_DOWN, S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
    logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
    logic [1:0]         op_q, op_d;
    logic               job_err_q, job_err_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [15:0]        blk_cnt_q, blk_cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               ip_en_q, ip_en_d;
    logic               ip_dma_valid_q, ip_dma_valid_d;
    logic [1:0]         ip_command_q, ip_command_d;
    logic               accept_c;
    logic               beat_c;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_OFF;
            cnt_q          <= '0;
            tmr_q          <= '0;
            op_q           <= '0;
            job_err_q      <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            blk_cnt_q      <= '0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            ip_en_q        <= 1'b0;
            ip_dma_valid_q <= 1'b0;
            ip_command_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            op_q           <= op_d;
            job_err_q      <= job_err_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            blk_cnt_q      <= blk_cnt_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            ip_en_q        <= ip_en_d;
            ip_dma_valid_q <= ip_dma_valid_d;
            ip_command_q   <= ip_command_d;
        end
    end

    // Next state, beat/phase counters and status events
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        op_d       = op_q;
        job_err_d  = job_err_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        blk_cnt_d  = blk_cnt_q;
        accept_c   = cmd_valid && cmd_ready_q;

        // Only the beat belonging to the active transfer is counted
        beat_c = 1'b0;
        if (state_q == S_BOOT) begin
            beat_c = s_beat;
        end else if (state_q == S_RUN) begin
            beat_c = (op_q == OP_UNLOAD) ? m_beat : s_beat;
        end
        cnt_nx  = cnt_q + CNT_W'(beat_c);
        tmr_inc = tmr_q + TMR_W'(1);

        case (state_q)
            S_OFF: begin
                if (accept_c) begin
                    if (cmd_op == OP_LOAD) begin
                        state_d   = S_BOOT;
                        cnt_d     = '0;
                        tmr_d     = '0;
                        job_err_d = 1'b0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = EC_ILLEGAL;
                    end
                end
            end
            S_BOOT: begin
                cnt_d = cnt_nx;
`ifdef IP_SEQ_WDOG_EN
                tmr_d = beat_c ? '0 : tmr_inc;
`endif
                if (cnt_nx == CNT_W'(BLOCK_LEN)) begin
                    state_d = S_HS_LO;
                    tmr_d   = '0;
                end
`ifdef IP_SEQ_WDOG_EN
                else if (!beat_c && tmr_inc == TMR_W'(WDOG_CYC)) begin
                    state_d    = S_ABORT;
                    tmr_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = EC_WDOG;
                end
`endif
            end
            S_READY: begin
                if (accept_c) begin
                    case (cmd_op)
                        OP_LOAD, OP_UNLOAD: begin
                            state_d   = S_ISSUE;
                            op_d      = cmd_op;
                            job_err_d = 1'b0;
                            cnt_d     = '0;
                        end
                        OP_SHUT: begin
                            state_d = S_DOWN;
                            tmr_d   = '0;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = EC_ILLEGAL;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_RUN;
                cnt_d   = '0;
                tmr_d   = '0;
            end
            S_RUN: begin
                cnt_d = cnt_nx;
`ifdef IP_SEQ_WDOG_EN
                tmr_d = beat_c ? '0 : tmr_inc;
`endif
                // tlast must coincide exactly with the final beat of an unload
                if (op_q == OP_UNLOAD && beat_c && m_last && cnt_nx != CNT_W'(BLOCK_LEN)) begin
                    state_d    = S_HS_LO;
                    tmr_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = EC_TLAST;
                    job_err_d  = 1'b1;
                end else if (cnt_nx == CNT_W'(BLOCK_LEN)) begin
                    state_d = S_HS_LO;
                    tmr_d   = '0;
                    if (op_q == OP_UNLOAD && !m_last) begin
                        err_d      = 1'b1;
                        err_code_d = EC_TLAST;
                        job_err_d  = 1'b1;
                    end
                end
`ifdef IP_SEQ_WDOG_EN
                else if (!beat_c && tmr_inc == TMR_W'(WDOG_CYC)) begin
                    state_d    = S_ABORT;
                    tmr_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = EC_WDOG;
                end
`endif
            end
            S_HS_LO: begin
                if (tmr_q == TMR_W'(HS_CYC - 1)) begin
                    state_d = S_HS_HI;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_HS_HI: begin
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    state_d   = S_READY;
                    tmr_d     = '0;
                    done_d    = !job_err_q;
                    // The IP block slot is consumed even when the job errored
                    blk_cnt_d = blk_cnt_q + 16'd1;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_DOWN: begin
                if (tmr_q == TMR_W'(1)) begin
                    state_d = S_OFF;
                    tmr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_ABORT: begin
                if (tmr_q == TMR_W'(1)) begin
                    state_d = S_OFF;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // Pin and status decode from the upcoming state, registered above
    always_comb begin
        cmd_ready_d    = (state_d == S_OFF) || (state_d == S_READY);
        busy_d         = !((state_d == S_OFF) || (state_d == S_READY));
        ip_en_d        = 1'b0;
        ip_dma_valid_d = 1'b0;
        ip_command_d   = '0;
        case (state_d)
            S_BOOT, S_READY, S_RUN, S_HS_HI: begin
                ip_en_d        = 1'b1;
                ip_dma_valid_d = 1'b1;
            end
            S_ISSUE: begin
                ip_en_d        = 1'b1;
                ip_dma_valid_d = 1'b1;
                ip_command_d   = op_d;
            end
            S_HS_LO: begin
                ip_en_d = 1'b1;
            end
            default: begin
                ip_en_d        = 1'b0;
                ip_dma_valid_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready    = cmd_ready_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign busy         = busy_q;
    assign blk_cnt      = blk_cnt_q;
    assign ip_en        = ip_en_q;
    assign ip_dma_valid = ip_dma_valid_q;
    assign ip_command   = ip_command_q;

endmodule

// File: tb/tb_ip_seq_ctrl.sv
// Directed testbench for ip_seq_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point.
module tb_ip_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] blk_cnt;
    logic        ip_en;
    logic        ip_dma_valid;
    logic [1:0]  ip_command;
    logic        s_beat;
    logic        m_beat;
    logic        m_last;

    int total;
    int bad;
    int done_cnt;
    int err_cnt;
    int cmd_cyc;
    logic [15:0] exp_blk;

    ip_seq_ctrl #(
        .BLOCK_LEN (32),
        .HS_CYC    (2),
        .SETTLE_CYC(2),
        .WDOG_CYC  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .busy        (busy),
        .blk_cnt     (blk_cnt),
        .ip_en       (ip_en),
        .ip_dma_valid(ip_dma_valid),
        .ip_command  (ip_command),
        .s_beat      (s_beat),
        .m_beat      (m_beat),
        .m_last      (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (ip_command !== 2'd0) cmd_cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        total++;
        if ({done, err, err_code, busy, ip_en, ip_dma_valid, ip_command} !== 8'd0) begin
            bad++; $display("FAIL rst_outs: got %b want 0", {done, err, err_code, busy, ip_en, ip_dma_valid, ip_command});
        end
        total++;
        if (blk_cnt !== 16'd0) begin bad++; $display("FAIL rst_blk: got %0d want 0", blk_cnt); end
        total++;
        rst = 1'b0;
        step(1);
        if (ip_en !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL off_idle: got en=%b rdy=%b want en=0 rdy=1", ip_en, cmd_ready);
        end
        total++;
    endtask

    task automatic test_boot_load();
        cmd_valid = 1'b1; cmd_op = 2'd1;
        step(1);
        cmd_valid = 1'b0;
        if ({ip_en, ip_dma_valid, cmd_ready, busy} !== 4'b1101) begin
            bad++; $display("FAIL boot_enter: got %b want 1101", {ip_en, ip_dma_valid, cmd_ready, busy});
        end
        total++;
        s_beat = 1'b1;
        step(31);
        if (ip_dma_valid !== 1'b1) begin bad++; $display("FAIL boot_beat31: got dma=%b want 1", ip_dma_valid); end
        total++;
        step(1);
        s_beat = 1'b0;
        if (ip_dma_valid !== 1'b0) begin bad++; $display("FAIL boot_hslo0: got dma=%b want 0", ip_dma_valid); end
        total++;
        step(1);
        if (ip_dma_valid !== 1'b0) begin bad++; $display("FAIL boot_hslo1: got dma=%b want 0", ip_dma_valid); end
        total++;
        step(1);
        if (ip_dma_valid !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL boot_hshi: got dma=%b done=%b want dma=1 done=0", ip_dma_valid, done);
        end
        total++;
        step(1);
        if (done !== 1'b0) begin bad++; $display("FAIL boot_settle: got done=%b want 0", done); end
        total++;
        step(1);
        exp_blk = exp_blk + 16'd1;
        if (done !== 1'b1 || blk_cnt !== exp_blk || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL boot_done: got done=%b blk=%0d rdy=%b busy=%b want 1 %0d 1 0", done, blk_cnt, cmd_ready, busy, exp_blk);
        end
        total++;
        step(1);
        if (done !== 1'b0) begin bad++; $display("FAIL boot_done_pulse: got done=%b want 0", done); end
        total++;
    endtask

    task automatic test_unload_ok();
        int e0;
        int c0;
        e0 = err_cnt; c0 = cmd_cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step(1);
        cmd_valid = 1'b0;
        if (ip_command !== 2'd2 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL unl_issue: got cmd=%0d rdy=%b want 2 0", ip_command, cmd_ready);
        end
        total++;
        step(1);
        if (ip_command !== 2'd0) begin bad++; $display("FAIL unl_cmd_clear: got %0d want 0", ip_command); end
        total++;
        for (int i = 0; i < 32; i++) begin
            m_beat = 1'b1; s_beat = 1'b1; m_last = (i == 31);
            step(1);
        end
        m_beat = 1'b0; s_beat = 1'b0; m_last = 1'b0;
        if (ip_dma_valid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL unl_rearm: got dma=%b err=%b want 0 0", ip_dma_valid, err);
        end
        total++;
        step(4);
        exp_blk = exp_blk + 16'd1;
        if (done !== 1'b1 || blk_cnt !== exp_blk) begin
            bad++; $display("FAIL unl_done: got done=%b blk=%0d want 1 %0d", done, blk_cnt, exp_blk);
        end
        total++;
        step(1);
        if (err_cnt != e0 || cmd_cyc != c0 + 1) begin
            bad++; $display("FAIL unl_pulses: got errs=%0d cmdcyc=%0d want 0 1", err_cnt - e0, cmd_cyc - c0);
        end
        total++;
    endtask

    // LOAD from READY with sparse s_beat and m_beat noise that must be ignored
    task automatic test_load_run();
        cmd_valid = 1'b1; cmd_op = 2'd1;
        step(1);
        cmd_valid = 1'b0;
        if (ip_command !== 2'd1) begin bad++; $display("FAIL load_issue: got %0d want 1", ip_command); end
        total++;
        step(1);
        for (int i = 0; i < 63; i++) begin
            s_beat = i[0]; m_beat = 1'b1; m_last = 1'b1;
            step(1);
        end
        if (ip_dma_valid !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL load_beat31: got dma=%b err=%b want 1 0", ip_dma_valid, err);
        end
        total++;
        s_beat = 1'b1;
        step(1);
        s_beat = 1'b0; m_beat = 1'b0; m_last = 1'b0;
        if (ip_dma_valid !== 1'b0) begin bad++; $display("FAIL load_beat32: got dma=%b want 0", ip_dma_valid); end
        total++;
        step(4);
        exp_blk = exp_blk + 16'd1;
        if (done !== 1'b1 || blk_cnt !== exp_blk) begin
            bad++; $display("FAIL load_done: got done=%b blk=%0d want 1 %0d", done, blk_cnt, exp_blk);
        end
        total++;
        step(1);
    endtask

    task automatic test_unload_tlast(input int nbeats, input bit last_on_final);
        int d0;
        d0 = done_cnt;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step(1);
        cmd_valid = 1'b0;
        step(1);
        for (int i = 0; i < nbeats; i++) begin
            m_beat = 1'b1; m_last = last_on_final && (i == nbeats - 1);
            step(1);
        end
        m_beat = 1'b0; m_last = 1'b0;
        if (err !== 1'b1 || err_code !== 2'd2 || ip_dma_valid !== 1'b0) begin
            bad++; $display("FAIL tlast_err_%0d: got err=%b code=%0d dma=%b want 1 2 0", nbeats, err, err_code, ip_dma_valid);
        end
        total++;
        step(4);
        exp_blk = exp_blk + 16'd1;
        if (done !== 1'b0 || blk_cnt !== exp_blk || cmd_ready !== 1'b1 || err_code !== 2'd2) begin
            bad++; $display("FAIL tlast_end_%0d: got done=%b blk=%0d rdy=%b code=%0d want 0 %0d 1 2", nbeats, done, blk_cnt, cmd_ready, err_code, exp_blk);
        end
        total++;
        step(1);
        if (done_cnt != d0) begin bad++; $display("FAIL tlast_nodone_%0d: got %0d dones want 0", nbeats, done_cnt - d0); end
        total++;
    endtask

    task automatic test_bad_op_ready();
        cmd_valid = 1'b1; cmd_op = 2'd0;
        step(1);
        cmd_valid = 1'b0;
        if (err !== 1'b1 || err_code !== 2'd1 || cmd_ready !== 1'b1 || ip_en !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rdy_badop: got err=%b code=%0d rdy=%b en=%b busy=%b want 1 1 1 1 0", err, err_code, cmd_ready, ip_en, busy);
        end
        total++;
        step(1);
        if (err !== 1'b0) begin bad++; $display("FAIL rdy_badop_pulse: got err=%b want 0", err); end
        total++;
    endtask

    task automatic test_shutdown();
        cmd_valid = 1'b1; cmd_op = 2'd3;
        step(1);
        cmd_valid = 1'b0;
        if ({ip_en, ip_dma_valid, busy, cmd_ready, done} !== 5'b00100) begin
            bad++; $display("FAIL shut_down: got %b want 00100", {ip_en, ip_dma_valid, busy, cmd_ready, done});
        end
        total++;
        step(1);
        if (done !== 1'b0) begin bad++; $display("FAIL shut_early: got done=%b want 0", done); end
        total++;
        step(1);
        if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || ip_en !== 1'b0) begin
            bad++; $display("FAIL shut_done: got done=%b rdy=%b busy=%b en=%b want 1 1 0 0", done, cmd_ready, busy, ip_en);
        end
        total++;
        if (blk_cnt !== exp_blk) begin bad++; $display("FAIL shut_blk: got %0d want %0d", blk_cnt, exp_blk); end
        total++;
        step(1);
    endtask

    task automatic test_off_illegal();
        cmd_valid = 1'b1; cmd_op = 2'd2;
        step(1);
        cmd_valid = 1'b0;
        if (err !== 1'b1 || err_code !== 2'd1 || ip_en !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL off_unload: got err=%b code=%0d en=%b rdy=%b busy=%b want 1 1 0 1 0", err, err_code, ip_en, cmd_ready, busy);
        end
        total++;
        step(1);
        if (err !== 1'b0 || ip_en !== 1'b0) begin
            bad++; $display("FAIL off_stay: got err=%b en=%b want 0 0", err, ip_en);
        end
        total++;
    endtask

    task automatic test_restart_reset();
        int d0;
        cmd_valid = 1'b1; cmd_op = 2'd1;
        step(1);
        cmd_valid = 1'b0;
        if (ip_en !== 1'b1 || ip_dma_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_boot: got en=%b dma=%b busy=%b want 1 1 1", ip_en, ip_dma_valid, busy);
        end
        total++;
        s_beat = 1'b1;
        step(3);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        if (cmd_ready !== 1'b1 || {done, err, err_code, busy, ip_en, ip_dma_valid, ip_command} !== 8'd0 || blk_cnt !== 16'd0) begin
            bad++; $display("FAIL async_rst: got rdy=%b outs=%b blk=%0d want 1 0 0", cmd_ready, {done, err, err_code, busy, ip_en, ip_dma_valid, ip_command}, blk_cnt);
        end
        total++;
        s_beat = 1'b0;
        exp_blk = 16'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(3);
        if (done_cnt != d0 || cmd_ready !== 1'b1 || ip_en !== 1'b0) begin
            bad++; $display("FAIL rst_nodone: got dones=%0d rdy=%b en=%b want 0 1 0", done_cnt - d0, cmd_ready, ip_en);
        end
        total++;
    endtask

`ifdef IP_SEQ_WDOG_EN
    task automatic test_wdog();
        cmd_valid = 1'b1; cmd_op = 2'd1;
        step(1);
        cmd_valid = 1'b0;
        s_beat = 1'b1;
        step(5);
        s_beat = 1'b0;
        step(15);
        if (err !== 1'b0 || ip_en !== 1'b1) begin
            bad++; $display("FAIL wdog_early: got err=%b en=%b want 0 1", err, ip_en);
        end
        total++;
        step(1);
        if (err !== 1'b1 || err_code !== 2'd3 || ip_en !== 1'b0 || ip_dma_valid !== 1'b0) begin
            bad++; $display("FAIL wdog_fire: got err=%b code=%0d en=%b dma=%b want 1 3 0 0", err, err_code, ip_en, ip_dma_valid);
        end
        total++;
        step(2);
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || blk_cnt !== exp_blk || done !== 1'b0) begin
            bad++; $display("FAIL wdog_off: got rdy=%b busy=%b blk=%0d done=%b want 1 0 %0d 0", cmd_ready, busy, blk_cnt, done, exp_blk);
        end
        total++;
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        done_cnt = 0; err_cnt = 0; cmd_cyc = 0;
        exp_blk = 16'd0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
        s_beat = 1'b0; m_beat = 1'b0; m_last = 1'b0;
        test_reset();
        test_boot_load();
        test_unload_ok();
        test_load_run();
        test_unload_tlast(31, 1'b1);
        test_unload_tlast(32, 1'b0);
        test_bad_op_ready();
        test_shutdown();
        test_off_illegal();
        test_restart_reset();
`ifdef IP_SEQ_WDOG_EN
        test_wdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_seq_ctrl.md
Name: ip_seq_ctrl

Overview:
- Sequencer for the 32-word AXI4-Stream buffer IP, which has en / DMA_VALID / command[1:0] control inputs.
- Accepts LOAD / UNLOAD / SHUTDOWN jobs from the PS-side register block and drives the IP control pins through the full handshake: enable, first load, DMA_VALID low/high re-arm, then command pulses.
- Counts stream beats to detect block completion and reports done/error back to software.

Parameters:
- BLOCK_LEN, 32, beats per block for both load and unload.
- HS_CYC, 2, cycles ip_dma_valid is held low during re-arm (minimum 1).
- SETTLE_CYC, 2, cycles after ip_dma_valid rises before accepting the next job.
- WDOG_CYC, 4096, watchdog limit in cycles without a beat (used only with the optional feature).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- cmd_valid, input, 1, job request.
- cmd_op, input, 2, job code: 1=LOAD, 2=UNLOAD, 3=SHUTDOWN, 0=reserved.
- cmd_ready, output, 1, controller can accept a job.
- done, output, 1, one-cycle pulse when a job completes without error.
- err, output, 1, one-cycle pulse when a job is rejected or aborted.
- err_code, output, 2, error cause: 1=illegal op, 2=tlast mismatch, 3=watchdog. Holds until the next err pulse.
- busy, output, 1, high in every state except OFF and READY.
- blk_cnt, output, 16, count of completed jobs; wraps at 65535.
- ip_en, output, 1, drives the IP en pin.
- ip_dma_valid, output, 1, drives the IP DMA_VALID pin.
- ip_command, output, 2, drives the IP command pin.
- s_beat, input, 1, IP slave handshake (s_valid & s_ready).
- m_beat, input, 1, IP master handshake (m_valid & m_ready).
- m_last, input, 1, IP m_tlast.

Behaviour:
- All outputs are registered. On reset: state OFF, cmd_ready=1, every other output 0, beat and timer counters 0, err_code=0.
- Job acceptance: a job is accepted on a cycle where cmd_valid & cmd_ready. cmd_ready deasserts on the following edge.
- Command pulse rule: ip_command is nonzero for exactly one cycle per issued job, and only in state ISSUE. It is 0 in every other state.
- States and transitions:
  - OFF: ip_en=0, ip_dma_valid=0.
    - LOAD accepted -> BOOT.
    - UNLOAD or SHUTDOWN accepted -> err pulse, err_code=1, stay OFF.
  - BOOT: ip_en=1, ip_dma_valid=1. Clear the beat counter on entry. Count s_beat.
    - When the count reaches BLOCK_LEN -> HS_LO.
  - READY: ip_en=1, ip_dma_valid=1, cmd_ready=1.
    - LOAD -> ISSUE with command 1.
    - UNLOAD -> ISSUE with command 2.
    - SHUTDOWN -> DOWN.
    - op 0 -> err, err_code=1, stay READY.
  - ISSUE: drive ip_command for one cycle, clear the beat counter, then go to RUN.
  - RUN: count s_beat for LOAD or m_beat for UNLOAD. Any beat not belonging to the active op is ignored.
    - UNLOAD, m_last seen on a beat before the count reaches BLOCK_LEN -> err, err_code=2, then HS_LO.
    - UNLOAD, last beat reaches BLOCK_LEN without m_last -> err, err_code=2, then HS_LO.
    - Otherwise, reaching BLOCK_LEN -> HS_LO.
  - HS_LO: ip_dma_valid=0 for HS_CYC cycles -> HS_HI.
  - HS_HI: ip_dma_valid=1 for SETTLE_CYC cycles. Then pulse done (only if no err occurred in this job), increment blk_cnt, go to READY.
  - DOWN: ip_en=0, ip_dma_valid=0 for 2 cycles. Then pulse done, go to OFF.
- Boundary conditions:
  - A beat and a state exit on the same cycle: the beat is counted before the exit decision.
  - blk_cnt increments on errored jobs too, because the IP block slot was consumed.
  - Reset asserted mid-job: all outputs return immediately to their reset values. No done is issued.
- Beat counter width is clog2(BLOCK_LEN)+1 and compares against BLOCK_LEN exactly.

Optional Feature:
- Macro: IP_SEQ_WDOG_EN.
- Defined:
  - In BOOT and RUN, a timer resets on every counted beat and increments otherwise.
  - When the timer reaches WDOG_CYC: err pulse, err_code=3, ip_en=0, ip_dma_valid=0 for 2 cycles, then OFF. blk_cnt is not incremented.
- Undefined:
  - No timer logic is built. BOOT and RUN wait indefinitely. err_code value 3 is never produced.

Test Plan:
- Reset, then LOAD in OFF, drive 32 s_beat -> ip_en and ip_dma_valid go 1. After beat 32, ip_dma_valid is low for 2 cycles, then high. done pulses 2 cycles later. blk_cnt=1, cmd_ready=1.
- From READY, UNLOAD with 32 m_beat, m_last on beat 32 -> ip_command=2 for exactly 1 cycle, then the re-arm sequence, done, blk_cnt=2, err never asserted.
- UNLOAD with m_last on beat 31 -> err pulse, err_code=2, no done, re-arm still performed, blk_cnt increments.
- UNLOAD issued in OFF -> err pulse with err_code=1 on the next cycle. ip_en stays 0 and the state stays OFF.
- SHUTDOWN from READY -> ip_en=0 and ip_dma_valid=0, done after 2 cycles, cmd_ready=1, busy=0. A following LOAD restarts BOOT.
- With IP_SEQ_WDOG_EN and WDOG_CYC=16: LOAD, stall after 5 beats -> err_code=3 at stall cycle 16, state returns to OFF. Separately, rst asserted mid-RUN -> all outputs return to 0 asynchronously.
